// File: rtl/fod_phase_ctrl.sv
// Fractional output divider phase sequencer.
// Accumulates the fractional control word once per output period, selects the
// multiphase tap from the accumulator MSBs and reloads the integer cycle
// counter with the period length. Configuration updates are applied only in
// IDLE or on a period boundary so the tap switch is always glitch-free.
module fod_phase_ctrl #(
  parameter int MP_SEG_BIN = 3,
  parameter int FCW_INT_W  = 6,
  parameter int FCW_FRAC_W = 16
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  en,
  input  logic                  cfg_req,
  input  logic [FCW_INT_W-1:0]  fcw_int,
  input  logic [FCW_FRAC_W-1:0] fcw_frac,
  output logic                  cfg_ack,
  output logic                  cfg_err,
  output logic [MP_SEG_BIN-1:0] phase_sel,
  output logic                  fod_pulse,
  output logic                  running
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STOP = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [FCW_INT_W-1:0]    cnt_q, cnt_d;
  logic [FCW_FRAC_W-1:0]   acc_q, acc_d;
  logic [FCW_INT_W-1:0]    int_s_q, int_s_d;
  logic [FCW_FRAC_W-1:0]   frac_s_q, frac_s_d;
  logic                    configured_q, configured_d;
  logic                    armed_q, armed_d;
  logic                    cfg_ack_q, cfg_ack_d;
  logic                    cfg_err_q, cfg_err_d;
  logic [MP_SEG_BIN-1:0]   phase_q, phase_d;
  logic                    pulse_q, pulse_d;

  logic                    boundary;
  logic                    consume;
  logic                    accept;
  logic [FCW_INT_W-1:0]    eff_int;
  logic [FCW_FRAC_W-1:0]   eff_frac;
  logic [FCW_FRAC_W:0]     sum;
  logic                    carry;

  // Boundary detect, request qualification and the new-period arithmetic.
  // A request accepted on a boundary already governs the period it starts.
  always_comb begin
    boundary = (state_q != ST_IDLE) && (cnt_q == '0);
    consume  = cfg_req && armed_q && ((state_q == ST_IDLE) || boundary);
    accept   = consume && (fcw_int >= FCW_INT_W'(2));
    eff_int  = accept ? fcw_int  : int_s_q;
    eff_frac = accept ? fcw_frac : frac_s_q;
    sum      = {1'b0, acc_q} + {1'b0, eff_frac};
    carry    = sum[FCW_FRAC_W];
  end

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic: dropping en on a boundary ends the run immediately.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (en && configured_q) state_d = ST_RUN;
      ST_RUN:  if (!en) state_d = boundary ? ST_IDLE : ST_STOP;
      ST_STOP: if (boundary) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM output decode.
  always_comb begin
    running = (state_q != ST_IDLE);
  end

  // Next values for counter, accumulator, shadow FCW and handshake flags.
  always_comb begin
    cnt_d        = cnt_q;
    acc_d        = acc_q;
    phase_d      = phase_q;
    pulse_d      = 1'b0;
    int_s_d      = int_s_q;
    frac_s_d     = frac_s_q;
    configured_d = configured_q;
    cfg_err_d    = cfg_err_q;
    cfg_ack_d    = consume;
    armed_d      = armed_q;
    if (consume)       armed_d = 1'b0;
    else if (!cfg_req) armed_d = 1'b1;
    if (accept) begin
      int_s_d      = fcw_int;
      frac_s_d     = fcw_frac;
      configured_d = 1'b1;
      cfg_err_d    = 1'b0;
    end else if (consume) begin
      cfg_err_d    = 1'b1;
    end
    if ((state_q == ST_IDLE) && (state_d == ST_RUN)) begin
      cnt_d   = eff_int - FCW_INT_W'(1);
      acc_d   = '0;
      phase_d = '0;
    end else if (boundary) begin
      acc_d   = sum[FCW_FRAC_W-1:0];
      phase_d = sum[FCW_FRAC_W-1 -: MP_SEG_BIN];
      cnt_d   = eff_int - FCW_INT_W'(1) + FCW_INT_W'(carry);
      pulse_d = 1'b1;
    end else if (state_q != ST_IDLE) begin
      cnt_d   = cnt_q - FCW_INT_W'(1);
    end
  end

  // Datapath and handshake registers; the request gate re-arms out of reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q        <= '0;
      acc_q        <= '0;
      phase_q      <= '0;
      pulse_q      <= 1'b0;
      int_s_q      <= '0;
      frac_s_q     <= '0;
      configured_q <= 1'b0;
      cfg_err_q    <= 1'b0;
      cfg_ack_q    <= 1'b0;
      armed_q      <= 1'b1;
    end else begin
      cnt_q        <= cnt_d;
      acc_q        <= acc_d;
      phase_q      <= phase_d;
      pulse_q      <= pulse_d;
      int_s_q      <= int_s_d;
      frac_s_q     <= frac_s_d;
      configured_q <= configured_d;
      cfg_err_q    <= cfg_err_d;
      cfg_ack_q    <= cfg_ack_d;
      armed_q      <= armed_d;
    end
  end

  assign cfg_ack   = cfg_ack_q;
  assign cfg_err   = cfg_err_q;
  assign phase_sel = phase_q;
  assign fod_pulse = pulse_q;

endmodule

// File: tb/tb_fod_phase_ctrl.sv
// Testbench for fod_phase_ctrl: directed scenarios followed by randomized
// traffic, compared every cycle against an event-time reference model.
module tb_fod_phase_ctrl;

  localparam int MP = 3;
  localparam int IW = 6;
  localparam int FW = 16;

  logic          clk = 1'b0;
  logic          rstn = 1'b1;
  logic          en = 1'b0;
  logic          cfg_req = 1'b0;
  logic [IW-1:0] fcw_int = '0;
  logic [FW-1:0] fcw_frac = '0;
  logic          cfg_ack, cfg_err, fod_pulse, running;
  logic [MP-1:0] phase_sel;

  fod_phase_ctrl #(.MP_SEG_BIN(MP), .FCW_INT_W(IW), .FCW_FRAC_W(FW)) dut (
    .clk(clk), .rstn(rstn), .en(en), .cfg_req(cfg_req),
    .fcw_int(fcw_int), .fcw_frac(fcw_frac),
    .cfg_ack(cfg_ack), .cfg_err(cfg_err), .phase_sel(phase_sel),
    .fod_pulse(fod_pulse), .running(running)
  );

  always #5 clk = ~clk;

  int vec_cnt = 0;
  int err_cnt = 0;

  // Reference model: tracks the absolute edge index of the next boundary
  // and the phase accumulator as a plain integer fraction.
  int          m_state;   // 0 idle, 1 run, 2 stop
  int unsigned m_edge, m_nb, m_acc, m_sh_int, m_sh_frac;
  bit          m_cfgd, m_armed;
  bit          x_ack, x_err, x_pulse;
  int unsigned x_phase;

  bit          cap_on = 1'b0;
  int unsigned cap_ph[$];
  int unsigned cap_t[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_edge = 0; m_nb = 0; m_acc = 0;
    m_sh_int = 0; m_sh_frac = 0; m_cfgd = 0; m_armed = 1;
    x_ack = 0; x_err = 0; x_pulse = 0; x_phase = 0;
  endtask

  task automatic model_edge();
    bit          bnd, cons, ok, old_cfgd;
    int unsigned si, sf, total, carry;
    m_edge++;
    bnd      = (m_state != 0) && (m_edge == m_nb);
    cons     = cfg_req && m_armed && ((m_state == 0) || bnd);
    ok       = cons && (32'(fcw_int) >= 2);
    si       = ok ? 32'(fcw_int) : m_sh_int;
    sf       = ok ? 32'(fcw_frac) : m_sh_frac;
    old_cfgd = m_cfgd;
    x_ack    = cons;
    if (cons) m_armed = 0;
    else if (!cfg_req) m_armed = 1;
    if (ok) begin
      m_sh_int = si; m_sh_frac = sf; m_cfgd = 1; x_err = 0;
    end else if (cons) begin
      x_err = 1;
    end
    x_pulse = 0;
    if (m_state == 0) begin
      if (en && old_cfgd) begin
        m_state = 1; m_acc = 0; x_phase = 0; m_nb = m_edge + si;
      end
    end else if (bnd) begin
      total   = m_acc + sf;
      carry   = (total >= (1 << FW)) ? 1 : 0;
      m_acc   = total % (1 << FW);
      x_phase = m_acc / (1 << (FW - MP));
      m_nb    = m_edge + si + carry;
      x_pulse = 1;
      if (m_state == 2 || !en) m_state = 0;
    end else if (m_state == 1 && !en) begin
      m_state = 2;
    end
  endtask

  task automatic step(input bit e_v, input bit r_v, input int unsigned i_v, input int unsigned f_v);
    en = e_v; cfg_req = r_v; fcw_int = IW'(i_v); fcw_frac = FW'(f_v);
    @(posedge clk);
    model_edge();
    #1;
    chk("cfg_ack", cfg_ack, x_ack);
    chk("cfg_err", cfg_err, x_err);
    chk("fod_pulse", fod_pulse, x_pulse);
    chk("phase_sel", phase_sel, x_phase);
    chk("running", running, m_state != 0);
    if (cap_on && fod_pulse) begin
      cap_ph.push_back(32'(phase_sel));
      cap_t.push_back(m_edge);
    end
  endtask

  task automatic do_cfg(input bit e_v, input int unsigned i_v, input int unsigned f_v);
    int n;
    n = 0;
    do begin
      step(e_v, 1'b1, i_v, f_v);
      n++;
    end while (!x_ack && n < 100);
    chk("cfg_ack_wait", cfg_ack, 1);
    step(e_v, 1'b0, i_v, f_v);
  endtask

  task automatic run(input bit e_v, input int n);
    for (int k = 0; k < n; k++) step(e_v, 1'b0, 0, 0);
  endtask

  task automatic async_reset();
    #1 rstn = 1'b0;
    #1;
    chk("rst_ack", cfg_ack, 0);
    chk("rst_err", cfg_err, 0);
    chk("rst_pulse", fod_pulse, 0);
    chk("rst_phase", phase_sel, 0);
    chk("rst_running", running, 0);
    model_reset();
    #1 rstn = 1'b1;
  endtask

  initial begin
    bit          e_r, rq;
    int unsigned ri, rf;
    model_reset();
    #1 rstn = 1'b0;
    #1;
    chk("por_ack", cfg_ack, 0);
    chk("por_err", cfg_err, 0);
    chk("por_pulse", fod_pulse, 0);
    chk("por_phase", phase_sel, 0);
    chk("por_running", running, 0);
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;

    // Basic run at 4/0, then stop.
    do_cfg(1'b0, 4, 0);
    run(1'b1, 30);
    run(1'b0, 10);

    // One-eighth step: phases 1..7,0 and one 5-cycle period after phase 0.
    do_cfg(1'b0, 4, 16'h2000);
    cap_on = 1'b1;
    run(1'b1, 45);
    cap_on = 1'b0;
    for (int k = 0; k < 8; k++)
      chk($sformatf("eighth_ph%0d", k), (k < cap_ph.size()) ? cap_ph[k] : 32'hFFFF, (k + 1) % 8);
    for (int k = 0; k < 8; k++)
      chk($sformatf("eighth_per%0d", k),
          (k + 1 < cap_t.size()) ? cap_t[k+1] - cap_t[k] : 32'hFFFF, (k == 7) ? 5 : 4);

    // Mid-run reconfiguration to 6/0, then a rejected request, then stop.
    do_cfg(1'b1, 6, 0);
    run(1'b1, 20);
    do_cfg(1'b1, 1, 0);
    run(1'b1, 15);
    run(1'b0, 15);

    // Half step: phases 4,0,4,0 with periods 4,5,4.
    cap_ph.delete(); cap_t.delete();
    do_cfg(1'b0, 4, 16'h8000);
    cap_on = 1'b1;
    run(1'b1, 25);
    cap_on = 1'b0;
    for (int k = 0; k < 4; k++)
      chk($sformatf("half_ph%0d", k), (k < cap_ph.size()) ? cap_ph[k] : 32'hFFFF, (k % 2 == 0) ? 4 : 0);
    for (int k = 0; k < 3; k++)
      chk($sformatf("half_per%0d", k),
          (k + 1 < cap_t.size()) ? cap_t[k+1] - cap_t[k] : 32'hFFFF, (k % 2 == 0) ? 4 : 5);

    // Asynchronous reset mid-period; en alone must not restart.
    run(1'b1, 6);
    async_reset();
    run(1'b1, 12);

    // Randomized traffic.
    e_r = 1'b1; rq = 1'b0; ri = 4; rf = 0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 59) == 0) e_r = !e_r;
      if (!rq && $urandom_range(0, 29) == 0) begin
        rq = 1'b1;
        if ($urandom_range(0, 7) == 0)       ri = $urandom_range(0, 1);
        else if ($urandom_range(0, 15) == 0) ri = 63;
        else                                 ri = $urandom_range(2, 12);
        rf = $urandom_range(0, 65535);
        if ($urandom_range(0, 3) == 0) rf = rf & 32'hE000;
      end
      step(e_r, rq, ri, rf);
      if (rq && x_ack) rq = 1'b0;
      if ($urandom_range(0, 699) == 0) async_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
